// File: rtl/md_unit_if.sv
// Handshake/bus bundle between the E stage and md_unit: instruction request,
// operands, and the busy/start/readback signals returned to the pipeline.
interface md_unit_if;
    logic        en;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    // Request side is sampled on every rising edge; there is no ready, the
    // unit raises start when it takes a MULT/DIV and holds busy while
    // it is running. The stall unit holds an md op in D while start|busy.
    modport master (
        output en, md_op, A, B,
        input  start, busy, md_out, hi, lo
    );

    modport slave (
        input  en, md_op, A, B,
        output start, busy, md_out, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// The result is computed at the start edge and committed N cycles later.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md,
    output logic       o_dbg_state
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_we;

    logic        w_busy;
    logic        w_is_md;
    logic        w_is_mult;
    logic        w_start;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_sden;
    logic [31:0] w_uden;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_we;

    assign w_busy    = (r_state == ST_RUN);
    assign w_is_md   = (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);
    assign w_is_mult = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
    assign w_start   = md.en && w_is_md && !w_busy;

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned product
    // equal to the signed product.
    assign w_prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    assign w_prod_u = {32'd0, md.A} * {32'd0, md.B};

    // Signed divide on magnitudes; a zero divisor is replaced by 1 only so the
    // dividers never see zero, the write-enable suppresses the commit.
    assign w_a_neg = md.A[31];
    assign w_b_neg = md.B[31];
    assign w_abs_a = w_a_neg ? (~md.A + 32'd1) : md.A;
    assign w_abs_b = w_b_neg ? (~md.B + 32'd1) : md.B;
    assign w_sden  = (md.B == 32'd0) ? 32'd1 : w_abs_b;
    assign w_uden  = (md.B == 32'd0) ? 32'd1 : md.B;
    assign w_q_mag = w_abs_a / w_sden;
    assign w_r_mag = w_abs_a % w_sden;
    assign w_uq    = md.A / w_uden;
    assign w_ur    = md.A % w_uden;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_we = 1'b0;
        case (md.md_op)
            OP_MULT: begin
                {w_res_hi, w_res_lo} = w_prod_s;
                w_res_we = 1'b1;
            end
            OP_MULTU: begin
                {w_res_hi, w_res_lo} = w_prod_u;
                w_res_we = 1'b1;
            end
            OP_DIV: begin
                w_res_lo = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
                w_res_hi = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
                w_res_we = (md.B != 32'd0);
            end
            OP_DIVU: begin
                w_res_lo = w_uq;
                w_res_hi = w_ur;
                w_res_we = (md.B != 32'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next_state = ST_RUN;
            ST_RUN:  if (r_cnt == 4'd1) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_we <= w_res_we;
                        r_cnt     <= w_is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    end else if (md.en) begin
                        if (md.md_op == OP_MTHI) r_hi <= md.A;
                        if (md.md_op == OP_MTLO) r_lo <= md.A;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1 && r_pend_we) begin
                        r_hi <= r_pend_hi;
                        r_lo <= r_pend_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md.start  = w_start;
    assign md.busy   = w_busy;
    assign md.hi     = r_hi;
    assign md.lo     = r_lo;
    assign md.md_out = !md.en                ? 32'd0 :
                       (md.md_op == OP_MFHI) ? r_hi  :
                       (md.md_op == OP_MFLO) ? r_lo  : 32'd0;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: multiply/divide latency and results, HI/LO moves,
// busy-time blocking, back-to-back starts and asynchronous reset mid-op.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset;
    logic dbg_state;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .md          (bus.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.en    = 1'b0;
        bus.md_op = 4'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
    endtask

    // Called at a falling edge while the unit is idle; returns at the falling
    // edge after busy has dropped.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [63:0] exp;
        old_hi = bus.hi;
        old_lo = bus.lo;
        exp_q.push_back({exp_hi, exp_lo});
        bus.en = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
        #1;
        chk({tag, " start"}, {31'd0, bus.start}, 32'd1);
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
            if (i == n - 1) begin
                chk({tag, " hi held"}, bus.hi, old_hi);
                chk({tag, " lo held"}, bus.lo, old_lo);
            end
            @(negedge clk);
        end
        chk({tag, " busy done"}, {31'd0, bus.busy}, 32'd0);
        exp = exp_q.pop_front();
        chk({tag, " hi"}, bus.hi, exp[63:32]);
        chk({tag, " lo"}, bus.lo, exp[31:0]);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        chk("reset start", {31'd0, bus.start}, 32'd0);
        chk("reset md_out", bus.md_out, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div neg div", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

        // MTHI then MFHI; MTLO then MFLO; en=0 masks md_out.
        bus.en = 1'b1; bus.md_op = 4'd7; bus.A = 32'h1234_5678;
        @(negedge clk);
        bus.md_op = 4'd5; bus.A = 32'd0;
        #1;
        chk("mfhi", bus.md_out, 32'h1234_5678);
        bus.md_op = 4'd8; bus.A = 32'hCAFE_F00D;
        @(negedge clk);
        bus.md_op = 4'd6;
        #1;
        chk("mflo", bus.md_out, 32'hCAFE_F00D);
        bus.en = 1'b0;
        #1;
        chk("mflo en0", bus.md_out, 32'd0);
        @(negedge clk);

        // Moves and new ops while busy are ignored; MFLO sees the old LO.
        bus.en = 1'b1; bus.md_op = 4'd1; bus.A = 32'd3; bus.B = 32'd4;
        @(negedge clk);
        bus.md_op = 4'd8; bus.A = 32'hDEAD_BEEF;
        #1;
        chk("busy mtlo start", {31'd0, bus.start}, 32'd0);
        @(negedge clk);
        bus.md_op = 4'd6;
        #1;
        chk("busy mflo", bus.md_out, 32'hCAFE_F00D);
        chk("busy lo kept", bus.lo, 32'hCAFE_F00D);
        bus.md_op = 4'd1; bus.A = 32'd9; bus.B = 32'd9;
        #1;
        chk("busy mult start", {31'd0, bus.start}, 32'd0);
        idle_inputs();
        repeat (4) @(negedge clk);
        chk("busy op busy", {31'd0, bus.busy}, 32'd0);
        chk("busy op hi", bus.hi, 32'd0);
        chk("busy op lo", bus.lo, 32'd12);

        // Second MULT held in E until the first one finishes.
        bus.en = 1'b1; bus.md_op = 4'd1; bus.A = 32'd5; bus.B = 32'd6;
        @(negedge clk);
        bus.A = 32'd7; bus.B = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            chk("b2b held start", {31'd0, bus.start}, 32'd0);
            chk("b2b busy1", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
        end
        chk("b2b gap busy", {31'd0, bus.busy}, 32'd0);
        chk("b2b first lo", bus.lo, 32'd30);
        chk("b2b first hi", bus.hi, 32'd0);
        chk("b2b restart", {31'd0, bus.start}, 32'd1);
        @(negedge clk);
        idle_inputs();
        chk("b2b busy2", {31'd0, bus.busy}, 32'd1);
        repeat (5) @(negedge clk);
        chk("b2b done", {31'd0, bus.busy}, 32'd0);
        chk("b2b hi", bus.hi, 32'hFFFF_FFFF);
        chk("b2b lo", bus.lo, 32'hFFFF_FFF9);

        // Asynchronous reset two cycles into a DIV.
        bus.en = 1'b1; bus.md_op = 4'd3; bus.A = 32'd100; bus.B = 32'd7;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        chk("rst mid busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst async busy", {31'd0, bus.busy}, 32'd0);
        chk("rst async hi", bus.hi, 32'd0);
        chk("rst async lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst no commit busy", {31'd0, bus.busy}, 32'd0);
        chk("rst no commit hi", bus.hi, 32'd0);
        chk("rst no commit lo", bus.lo, 32'd0);

        // en=0 leaves state alone.
        bus.en = 1'b0; bus.md_op = 4'd7; bus.A = 32'h5555_AAAA;
        @(negedge clk);
        chk("en0 mthi", bus.hi, 32'd0);
        bus.md_op = 4'd1;
        #1;
        chk("en0 start", {31'd0, bus.start}, 32'd0);
        @(negedge clk);
        chk("en0 busy", {31'd0, bus.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers. Sits in the E stage of the 5-stage MIPS pipeline.
- It is the source side of the md-hazard path: it drives `busy`, and the hazard/stall unit consumes `busy` to hold any md instruction in D.
- It also serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (1..15)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- en  input  1  E-stage instruction is valid (low for a bubble)
- md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 treated as NONE
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- start  output  1  combinational: en & md_op in {1..4} & !busy
- busy  output  1  registered; operation in flight
- md_out  output  32  combinational: HI when md_op=MFHI, LO when md_op=MFLO, else 0
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending results=0. Reset mid-operation discards the operation; HI/LO stay 0.
- State machine: IDLE, RUN.
- IDLE → RUN at a rising edge with start=1:
  - compute the result combinationally from A and B, latch it into pending_hi/pending_lo;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - set busy=1.
- RUN: counter decrements each edge. At the edge where counter==1:
  - commit pending to HI/LO;
  - clear busy;
  - return to IDLE.
  - Net effect: busy is high for exactly N cycles after the start edge, and HI/LO change at the edge ending the N-th busy cycle.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 → 64-bit product. MULTU: unsigned.
  - DIV: lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend. DIVU: unsigned.
  - DIV with A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (B=0): busy runs the full DIV_CYCLES, but HI/LO are left unchanged at commit.
- MTHI/MTLO: when en=1 and busy=0, hi (or lo) ← A at the edge.
- While busy=1:
  - MTHI/MTLO and new MULT/DIV are ignored; start stays 0;
  - MFHI/MFLO return the old (uncommitted) HI/LO.
  - The stall unit must stall D whenever the E-stage op is in 1..8 and (start | busy), so none of these cases occurs in legal pipeline operation.
- Simultaneous events: start is blocked during the commit edge because busy=1 until that edge. A start is accepted at the earliest on the edge after busy falls.
- en=0: no state change; start=0; md_out=0.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3, MULT_CYCLES=5 → busy high for cycles 1..5 after the start edge; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy low on cycle 6.
- MULTU A=0xFFFFFFFF, B=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV A=-7 (0xFFFFFFF9), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. DIVU A=7, B=0 → busy 10 cycles, hi/lo unchanged.
- MTHI A=0x12345678, then MFHI → md_out=0x12345678 on the next cycle. MTLO issued while busy → lo unchanged; MFLO during busy returns the pre-op lo.
- Start MULT, second MULT held in E while busy → start=0 until busy falls; the second op starts on the first idle edge and its result reflects its own operands.
- Assert reset low 2 cycles into a DIV → busy=0, hi=lo=0 immediately (asynchronous); after release, no commit occurs.
